// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, reads four big-endian bytes per instruction word and
// hands the assembled word to decode on a valid/ready handshake; honours redirects.
module instr_fetch_unit #(
   parameter int          ADDR_W   = 5,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic              clk,
   input  logic              reset_n,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [7:0]        mem_data,
   output logic [31:0]       instr,
   output logic [31:0]       instr_pc,
   output logic              instr_valid,
   input  logic              instr_ready,
   input  logic              redirect,
   input  logic [31:0]       redirect_pc,
   output logic              align_err
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_DRAIN,
      S_HOLD
   } state_t;

   state_t            state_q, state_d;
   logic [1:0]        idx_q, idx_d;
   logic [31:0]       pc_q, pc_d;
   logic [23:0]       shadow_q, shadow_d;
   logic [31:0]       instr_q, instr_d;
   logic [31:0]       instr_pc_q, instr_pc_d;
   logic              valid_q, valid_d;
   logic              align_q, align_d;
   logic              mem_rd_q, mem_rd_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
      state_d    = state_q;
      idx_d      = idx_q;
      pc_d       = pc_q;
      shadow_d   = shadow_q;
      instr_d    = instr_q;
      instr_pc_d = instr_pc_q;
      valid_d    = valid_q;
      align_d    = 1'b0;

      case (state_q)
         S_IDLE: begin
            state_d = S_FETCH;
            idx_d   = 2'd0;
         end
         S_FETCH: begin
            // Byte k-1 arrives while byte k is being requested; idx 0 has nothing to catch.
            case (idx_q)
               2'd1:    shadow_d[23:16] = mem_data;
               2'd2:    shadow_d[15:8]  = mem_data;
               2'd3:    shadow_d[7:0]   = mem_data;
               default: ;
            endcase
            if (idx_q == 2'd3) begin
               state_d = S_DRAIN;
            end else begin
               idx_d = 2'(idx_q + 2'd1);
            end
         end
         S_DRAIN: begin
            instr_d    = {shadow_q, mem_data};
            instr_pc_d = pc_q;
            valid_d    = 1'b1;
            state_d    = S_HOLD;
         end
         S_HOLD: begin
            if (valid_q && instr_ready) begin
               valid_d = 1'b0;
               pc_d    = pc_q + 32'd4;
               idx_d   = 2'd0;
               state_d = S_FETCH;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // A redirect overrides everything above, including a same-cycle handshake.
      if (redirect && (state_q != S_IDLE)) begin
         pc_d     = {redirect_pc[31:2], 2'b00};
         idx_d    = 2'd0;
         shadow_d = '0;
         valid_d  = 1'b0;
         state_d  = S_FETCH;
         align_d  = |redirect_pc[1:0];
      end

      mem_rd_d   = (state_d == S_FETCH);
      mem_addr_d = mem_rd_d ? pc_d[ADDR_W-1:0] + ADDR_W'(idx_d) : mem_addr_q;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         idx_q      <= 2'd0;
         pc_q       <= RESET_PC;
         shadow_q   <= '0;
         instr_q    <= '0;
         instr_pc_q <= '0;
         valid_q    <= 1'b0;
         align_q    <= 1'b0;
         mem_rd_q   <= 1'b0;
         mem_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         pc_q       <= pc_d;
         shadow_q   <= shadow_d;
         instr_q    <= instr_d;
         instr_pc_q <= instr_pc_d;
         valid_q    <= valid_d;
         align_q    <= align_d;
         mem_rd_q   <= mem_rd_d;
         mem_addr_q <= mem_addr_d;
      end
   end

   assign mem_rd      = mem_rd_q;
   assign mem_addr    = mem_addr_q;
   assign instr       = instr_q;
   assign instr_pc    = instr_pc_q;
   assign instr_valid = valid_q;
   assign align_err   = align_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus random ready/redirect traffic,
// with a scoreboard that predicts each delivered (pc, word) from the memory image.
module tb_instr_fetch_unit;

   localparam int          ADDR_W   = 5;
   localparam int          MEM_SZ   = 1 << ADDR_W;
   localparam logic [31:0] RESET_PC = 32'h0;

   logic              clk;
   logic              reset_n;
   logic              mem_rd;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_data;
   logic [31:0]       instr;
   logic [31:0]       instr_pc;
   logic              instr_valid;
   logic              instr_ready;
   logic              redirect;
   logic [31:0]       redirect_pc;
   logic              align_err;

   instr_fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .mem_rd      (mem_rd),
      .mem_addr    (mem_addr),
      .mem_data    (mem_data),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .align_err   (align_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [7:0] mem [MEM_SZ];

   // Byte-wide memory: data appears the cycle after the read request.
   always @(posedge clk) begin
      if (mem_rd) mem_data <= mem[mem_addr];
   end

   int errors = 0;
   int checks = 0;
   int delivered = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference: the word at pc is four consecutive bytes, big-endian, address wrapping.
   function automatic logic [31:0] word_at(input logic [31:0] pc);
      logic [31:0] w;
      w = '0;
      for (int k = 0; k < 4; k++) begin
         w = {w[23:0], mem[(pc + k) % MEM_SZ]};
      end
      return w;
   endfunction

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] word;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] model_pc;
   logic        exp_align;
   logic        prev_rst;
   int          stall;

   function automatic exp_t make_exp(input logic [31:0] pc);
      exp_t e;
      e.pc   = pc;
      e.word = word_at(pc);
      return e;
   endfunction

   // Monitor + model: compares on each handshake, then advances the model PC.
   always @(negedge clk) begin
      exp_t e;
      logic deliver;
      if (!reset_n) begin
         exp_q.delete();
         exp_align = 1'b0;
         prev_rst  = 1'b0;
         stall     = 0;
      end else begin
         check("align_err", {31'd0, align_err}, {31'd0, exp_align});
         deliver = instr_valid && instr_ready;
         if (deliver) begin
            stall = 0;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_unexpected: got instr_pc %h with nothing expected", instr_pc);
            end else begin
               e = exp_q.pop_front();
               check("sb_pc", instr_pc, e.pc);
               check("sb_instr", instr, e.word);
               delivered++;
            end
         end else begin
            stall++;
         end
         if (stall > 200) begin
            checks++;
            errors++;
            $display("FAIL sb_timeout: got no delivery for %0d cycles, expected one", stall);
            stall = 0;
         end
         exp_align = 1'b0;
         if (!prev_rst) begin
            model_pc = RESET_PC;
            exp_q.push_back(make_exp(model_pc));
         end else if (redirect) begin
            if (!deliver && exp_q.size() > 0) e = exp_q.pop_front();
            model_pc  = {redirect_pc[31:2], 2'b00};
            exp_align = (redirect_pc[1:0] != 2'b00);
            exp_q.push_back(make_exp(model_pc));
         end else if (deliver) begin
            model_pc = model_pc + 32'd4;
            exp_q.push_back(make_exp(model_pc));
         end
         prev_rst = 1'b1;
      end
   end

   task automatic wait_valid(input int max, output int n);
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!instr_valid && n < max);
      if (!instr_valid) begin
         checks++;
         errors++;
         $display("FAIL valid_timeout: got instr_valid 0 after %0d cycles, expected 1", n);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int n;
      int d0;
      logic [31:0] held_instr;

      reset_n     = 1'b0;
      instr_ready = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
      for (int i = 0; i < MEM_SZ; i++) mem[i] = 8'($urandom);
      mem[0] = 8'h8C;
      mem[1] = 8'h01;
      mem[2] = 8'h00;
      mem[3] = 8'h04;

      // Reset state, then first word latency.
      repeat (3) step();
      check("rst_instr", instr, 32'h0);
      check("rst_instr_pc", instr_pc, 32'h0);
      check("rst_valid", {31'd0, instr_valid}, 32'd0);
      check("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
      check("rst_mem_addr", {27'd0, mem_addr}, 32'd0);
      check("rst_align", {31'd0, align_err}, 32'd0);
      reset_n = 1'b1;
      wait_valid(20, n);
      check("first_latency", n, 6);
      check("first_instr", instr, 32'h8C010004);
      check("first_pc", instr_pc, 32'h0);

      // Back-pressure: everything holds while ready is low.
      held_instr = instr;
      for (int i = 0; i < 10; i++) begin
         step();
         check("hold_valid", {31'd0, instr_valid}, 32'd1);
         check("hold_instr", instr, held_instr);
         check("hold_pc", instr_pc, 32'h0);
         check("hold_mem_rd", {31'd0, mem_rd}, 32'd0);
      end
      instr_ready = 1'b1;
      step();
      instr_ready = 1'b0;
      check("pc4_mem_rd", {31'd0, mem_rd}, 32'd1);
      check("pc4_mem_addr", {27'd0, mem_addr}, 32'd4);
      wait_valid(20, n);
      check("fetch_latency", n, 5);
      check("pc4_pc", instr_pc, 32'h4);
      check("pc4_instr", instr, word_at(32'h4));

      // Redirect during FETCH idx2.
      instr_ready = 1'b1;
      step();
      instr_ready = 1'b0;
      step();
      step();
      redirect    = 1'b1;
      redirect_pc = 32'h10;
      step();
      redirect = 1'b0;
      check("redir_align", {31'd0, align_err}, 32'd0);
      check("redir_mem_addr", {27'd0, mem_addr}, 32'd16);
      check("redir_valid", {31'd0, instr_valid}, 32'd0);
      wait_valid(20, n);
      check("redir_latency", n, 5);
      check("redir_pc", instr_pc, 32'h10);
      check("redir_instr", instr, word_at(32'h10));

      // Misaligned redirect from HOLD, then address wrap.
      redirect    = 1'b1;
      redirect_pc = 32'h0000001E;
      step();
      redirect = 1'b0;
      check("misalign_pulse", {31'd0, align_err}, 32'd1);
      check("misalign_valid", {31'd0, instr_valid}, 32'd0);
      check("misalign_addr", {27'd0, mem_addr}, 32'd28);
      step();
      check("misalign_pulse_end", {31'd0, align_err}, 32'd0);
      wait_valid(20, n);
      check("pc1c_pc", instr_pc, 32'h1C);
      check("pc1c_instr", instr, word_at(32'h1C));
      instr_ready = 1'b1;
      step();
      instr_ready = 1'b0;
      check("wrap_mem_addr", {27'd0, mem_addr}, 32'd0);
      wait_valid(20, n);
      check("wrap_pc", instr_pc, 32'h20);
      check("wrap_instr", instr, 32'h8C010004);

      // Handshake and redirect in the same cycle.
      instr_ready = 1'b1;
      redirect    = 1'b1;
      redirect_pc = 32'h8;
      step();
      instr_ready = 1'b0;
      redirect    = 1'b0;
      check("hs_redir_valid", {31'd0, instr_valid}, 32'd0);
      check("hs_redir_addr", {27'd0, mem_addr}, 32'd8);
      wait_valid(20, n);
      check("hs_redir_pc", instr_pc, 32'h8);
      check("hs_redir_instr", instr, word_at(32'h8));

      // Asynchronous reset during FETCH idx3.
      instr_ready = 1'b1;
      step();
      instr_ready = 1'b0;
      step();
      step();
      step();
      reset_n = 1'b0;
      #1;
      check("arst_instr", instr, 32'h0);
      check("arst_instr_pc", instr_pc, 32'h0);
      check("arst_valid", {31'd0, instr_valid}, 32'd0);
      check("arst_mem_rd", {31'd0, mem_rd}, 32'd0);
      check("arst_mem_addr", {27'd0, mem_addr}, 32'd0);
      repeat (2) step();
      reset_n = 1'b1;
      wait_valid(20, n);
      check("restart_latency", n, 6);
      check("restart_pc", instr_pc, RESET_PC);
      check("restart_instr", instr, 32'h8C010004);

      // Random traffic, checked entirely by the scoreboard.
      d0 = delivered;
      for (int i = 0; i < 1500; i++) begin
         step();
         instr_ready = ($urandom_range(0, 3) != 0);
         redirect    = ($urandom_range(0, 19) == 0);
         redirect_pc = 32'($urandom_range(0, 63));
      end
      step();
      instr_ready = 1'b0;
      redirect    = 1'b0;
      step();
      check("random_progress", {31'd0, (delivered - d0) > 50}, 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
